// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one fixed-latency AES core between two requesters.
// Round-robin grant in IDLE, latch the winning plaintext/key, one-cycle
// cs/we issue, count out the core latency, then hold the tagged ciphertext
// on a valid/ready response channel. One job in flight at a time.
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   reqN_valid/ready/data/key  requester N job channel (N = 0,1)
//   core_cs/we/indata/key      issue side of the AES core
//   core_out                   ciphertext from the core
//   rsp_valid/ready/data/id    response channel, id = owning requester
//   busy                       FSM not in IDLE
module aes_core_arbiter #(
  parameter int DATA_W   = 128,
  parameter int CORE_LAT = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req0_key,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req1_key,
  output logic              core_cs,
  output logic              core_we,
  output logic [DATA_W-1:0] core_indata,
  output logic [DATA_W-1:0] core_key,
  input  logic [DATA_W-1:0] core_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] lat_data, lat_key;
  logic              lat_id;
  logic [7:0]        cnt;
  logic              last_grant;
  logic              grant;
  logic              hs;

  // Contested grant goes to whoever did not win last; last_grant resets
  // to 1 so the first contested grant after reset lands on requester 0.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end

  // Readies are gated by reset so every output is 0 while reset is held,
  // even if a requester is already presenting valid.
  assign req0_ready = reset && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = reset && (state == IDLE) && req1_valid &&  grant;
  assign hs         = req0_ready || req1_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    core_cs     = 1'b0;
    core_we     = 1'b0;
    core_indata = '0;
    core_key    = '0;
    rsp_valid   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:  if (hs) state_nxt = ISSUE;
      ISSUE: begin
        core_cs     = 1'b1;
        core_we     = 1'b1;
        core_indata = lat_data;
        core_key    = lat_key;
        state_nxt   = WAIT;
      end
      WAIT: begin
        core_cs     = 1'b1;
        core_indata = lat_data;
        core_key    = lat_key;
        if (cnt == 8'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, latency counter and response capture. The counter is loaded
  // with CORE_LAT-1 during ISSUE so WAIT spans exactly CORE_LAT cycles and
  // core_out is sampled on the last of them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_data   <= '0;
      lat_key    <= '0;
      lat_id     <= 1'b0;
      cnt        <= 8'd0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            lat_data   <= req0_data;
            lat_key    <= req0_key;
            lat_id     <= 1'b0;
            last_grant <= 1'b0;
          end else if (req1_ready) begin
            lat_data   <= req1_data;
            lat_key    <= req1_key;
            lat_id     <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        ISSUE: cnt <= 8'(CORE_LAT - 1);
        WAIT: begin
          if (cnt == 8'd0) begin
            rsp_data <= core_out;
            rsp_id   <= lat_id;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES encryption core (ports clk, reset, cs, we, Indata, Key, out) between two independent requesters.
- Arbitrates round-robin, latches the winning plaintext/key pair, and drives a single cs/we issue sequence into the core.
- Waits the core's fixed latency, then returns the ciphertext tagged with the requester id over a valid/ready response channel.
- Sits directly above the AES core; one job in flight at a time.

Parameters:
DATA_W, 128, width of plaintext, key and ciphertext
CORE_LAT, 11, cycles from the core_we issue cycle until core_out is valid; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a job
req0_ready  output  1  requester 0 job accepted this cycle when valid&ready
req0_data  input  DATA_W  requester 0 plaintext
req0_key  input  DATA_W  requester 0 key
req1_valid  input  1  requester 1 has a job
req1_ready  output  1  requester 1 handshake
req1_data  input  DATA_W  requester 1 plaintext
req1_key  input  DATA_W  requester 1 key
core_cs  output  1  core chip select
core_we  output  1  core write/start strobe
core_indata  output  DATA_W  plaintext to core
core_key  output  DATA_W  key to core
core_out  input  DATA_W  ciphertext from core
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  ciphertext
rsp_id  output  1  requester that owns rsp_data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; all outputs 0.
  - Latched data/key/id, rsp_data and counter = 0; last_grant = 1.
  - Any in-flight job is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = 0 if only req0_valid; 1 if only req1_valid; if both valid, grant = ~last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N, combinational. At most one ready is high per cycle. Both readies are 0 outside IDLE.
  - On handshake: latch reqN_data, reqN_key and id=N; last_grant<=N; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - core_cs=1, core_we=1.
  - core_indata/core_key = latched values.
  - Load counter = CORE_LAT-1; go to WAIT.
- WAIT:
  - core_cs=1, core_we=0; core_indata/core_key held stable.
  - If counter==0: capture core_out into rsp_data, id into rsp_id; go to RESP.
  - Otherwise decrement the counter.
  - WAIT lasts exactly CORE_LAT cycles.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id held stable until rsp_ready.
  - On rsp_valid&rsp_ready: go to IDLE; rsp_valid drops the next cycle.
  - Backpressure is unbounded; no new job is accepted while in RESP.
- core_indata/core_key are 0 in IDLE and RESP.
- Latency: handshake edge T → ISSUE at T+1 → rsp_valid first high at T+2+CORE_LAT.
- Minimum job spacing: CORE_LAT+3 cycles with rsp_ready held high.
- Changes on reqN inputs after handshake have no effect on the in-flight job.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…; the first grant after reset goes to 0.
- Reset deasserted mid-RESP or mid-WAIT: the FSM resumes from IDLE; no stale rsp_valid.

Test Plan:
- Single job: req0 plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c; core model returns 3925841d02dc09fbdc118597196a0b32 after CORE_LAT=11 → core_we pulses exactly 1 cycle; rsp_valid rises 13 cycles after handshake; rsp_data matches; rsp_id=0.
- Simultaneous valid on req0 and req1 from reset, held for 4 jobs → grant order 0,1,0,1; rsp_id sequence matches; never both readies high.
- Only req1 valid, three back-to-back jobs → all served; rsp_id=1 each; job spacing 14 cycles with rsp_ready=1.
- rsp_ready held low 20 cycles in RESP → rsp_valid, rsp_data, rsp_id stable; req0_ready/req1_ready stay 0; busy=1.
- Change req0_data to 0 during WAIT → core_indata unchanged; response still 3925841d02dc09fbdc118597196a0b32.
- Assert reset in WAIT cycle 5 → all outputs 0 immediately; after release, no response for the dropped job; next simultaneous request is granted to req0.
